// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for 16-bit (parameterisable) signed stereo samples.
// Generates bit clock, word select and serial data from audio_clk. A one-deep
// holding register accepts a pair at any time; the pair moves into the frame
// register at the next frame boundary and is serialised during that frame.
//
// Ports:
//   audio_clk        sole clock
//   rst_in           asynchronous active-high reset
//   left_in/right_in signed sample pair, captured only on accept
//   sample_valid_in  offer a pair this cycle
//   sample_ready_out holding register empty
//   i2s_bclk         bit clock, 50% duty, period 2*BCLK_HALF cycles
//   i2s_lrclk        word select (0 = left, 1 = right)
//   i2s_sdata        serial data, MSB first, one-bit I2S delay
//   frame_start_out  one-cycle pulse at each frame boundary
//   underrun_out     one-cycle pulse: boundary found the holding register empty
//   overflow_out     one-cycle pulse: an offer was rejected
module i2s_tx #(
  parameter int unsigned BCLK_HALF    = 32,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                           audio_clk,
  input  logic                           rst_in,
  input  logic signed [SAMPLE_WIDTH-1:0] left_in,
  input  logic signed [SAMPLE_WIDTH-1:0] right_in,
  input  logic                           sample_valid_in,
  output logic                           sample_ready_out,
  output logic                           i2s_bclk,
  output logic                           i2s_lrclk,
  output logic                           i2s_sdata,
  output logic                           frame_start_out,
  output logic                           underrun_out,
  output logic                           overflow_out
);

  localparam int unsigned     DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    bclk_q, bclk_d;
  logic [5:0]              bit_q, bit_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                    full_q, full_d;
  logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d;
  logic [SAMPLE_WIDTH-1:0] frame_r_q, frame_r_d;
  logic                    fstart_q, fstart_d;
  logic                    under_q, under_d;
  logic                    over_q, over_d;

  logic                    fall_evt;
  logic                    boundary;
  logic                    accept;
  logic [5:0]              bit_nxt;
  logic [4:0]              pos;
  logic [SAMPLE_WIDTH-1:0] word;
  logic [31:0]             slot;

  assign fall_evt = (div_q == DIV_LAST) && bclk_q;
  assign boundary = fall_evt && (bit_q == 6'd63);
  // The boundary frees the holding slot in the same cycle it is copied out,
  // so an offer on that exact cycle is taken even though ready reads 0.
  assign accept   = sample_valid_in && (!full_q || boundary);
  assign bit_nxt  = bit_q + 6'd1;
  assign pos      = bit_nxt[4:0];
  assign word     = bit_nxt[5] ? frame_r_q : frame_l_q;

  // Slot image: bit 31 is the one-bit delay, the word sits MSB-first right
  // below it, the rest is zero padding. Slot position p maps to bit 31-p.
  always_comb begin
    slot = '0;
    slot[30 -: SAMPLE_WIDTH] = word;
  end

  always_comb begin
    div_d     = div_q + DIV_W'(1);
    bclk_d    = bclk_q;
    bit_d     = bit_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    full_d    = full_q;
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    fstart_d  = 1'b0;
    under_d   = 1'b0;
    over_d    = sample_valid_in && !accept;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = !bclk_q;
    end

    if (fall_evt) begin
      bit_d   = bit_nxt;
      lrclk_d = bit_nxt[5];
      sdata_d = slot[5'd31 - pos];
    end

    if (boundary) begin
      fstart_d = 1'b1;
      if (full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        full_d    = 1'b0;
      end else begin
        under_d = 1'b1;
      end
    end

    if (accept) begin
      hold_l_d = left_in;
      hold_r_d = right_in;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_q     <= '0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      full_q    <= 1'b0;
      frame_l_q <= '0;
      frame_r_q <= '0;
      fstart_q  <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_q     <= bit_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      full_q    <= full_d;
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
      fstart_q  <= fstart_d;
      under_q   <= under_d;
      over_q    <= over_d;
    end
  end

  assign sample_ready_out = !full_q;
  assign i2s_bclk         = bclk_q;
  assign i2s_lrclk        = lrclk_q;
  assign i2s_sdata        = sdata_q;
  assign frame_start_out  = fstart_q;
  assign underrun_out     = under_q;
  assign overflow_out     = over_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized bench for i2s_tx with a frame-level reference model
// and an independent I2S receiver that decodes the serial pins.
module tb_i2s_tx;

  localparam int BH    = 32;
  localparam int SW    = 16;
  localparam int FRAME = 64 * 2 * BH;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] left_s = '0;
  logic signed [15:0] right_s = '0;
  logic               valid = 1'b0;
  logic               ready, bclk, lrclk, sdata, fs, ur, ov;

  always #5 clk = ~clk;

  i2s_tx #(.BCLK_HALF(BH), .SAMPLE_WIDTH(SW)) dut (
    .audio_clk        (clk),
    .rst_in           (rst),
    .left_in          (left_s),
    .right_in         (right_s),
    .sample_valid_in  (valid),
    .sample_ready_out (ready),
    .i2s_bclk         (bclk),
    .i2s_lrclk        (lrclk),
    .i2s_sdata        (sdata),
    .frame_start_out  (fs),
    .underrun_out     (ur),
    .overflow_out     (ov)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Frame-level model: edges counted since reset release; every FRAME-th
  // edge is a boundary. The pair playing in a frame is m_cur.
  int          cyc = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_hold = '0;
  logic [31:0] m_cur = '0;
  logic        e_fs = 1'b0, e_ur = 1'b0, e_ov = 1'b0;
  logic [31:0] exp_q[$];

  task automatic model_edge(input logic v, input logic [31:0] pair);
    bit bnd;
    cyc++;
    bnd  = (cyc % FRAME == 0);
    e_fs = bnd;
    e_ur = 1'b0;
    e_ov = 1'b0;
    if (bnd) begin
      exp_q.push_back(m_cur);
      if (m_full) begin
        m_cur  = m_hold;
        m_full = 1'b0;
      end else begin
        e_ur = 1'b1;
      end
    end
    if (v) begin
      if (!m_full) begin
        m_hold = pair;
        m_full = 1'b1;
      end else begin
        e_ov = 1'b1;
      end
    end
  endtask

  task automatic check_pins();
    int bc;
    bc = (cyc / (2 * BH)) % 64;
    expect_eq("bclk", 32'(bclk), 32'((cyc / BH) % 2));
    expect_eq("lrclk", 32'(lrclk), 32'(bc >= 32));
    expect_eq("frame_start", 32'(fs), 32'(e_fs));
    expect_eq("underrun", 32'(ur), 32'(e_ur));
    expect_eq("overflow", 32'(ov), 32'(e_ov));
    expect_eq("ready", 32'(ready), 32'(!m_full));
  endtask

  task automatic check_reset(input string tag);
    expect_eq({tag, "_bclk"}, 32'(bclk), 0);
    expect_eq({tag, "_lrclk"}, 32'(lrclk), 0);
    expect_eq({tag, "_sdata"}, 32'(sdata), 0);
    expect_eq({tag, "_ready"}, 32'(ready), 1);
    expect_eq({tag, "_fs"}, 32'(fs), 0);
    expect_eq({tag, "_ur"}, 32'(ur), 0);
    expect_eq({tag, "_ov"}, 32'(ov), 0);
  endtask

  task automatic step(input logic v, input logic [31:0] pair);
    valid   = v;
    left_s  = pair[31:16];
    right_s = pair[15:0];
    @(posedge clk);
    model_edge(v, pair);
    @(negedge clk);
    valid = 1'b0;
    check_pins();
  endtask

  // Run until cyc == stop; offer pair on edge number 'at' (0 = no offer).
  task automatic run_to(input int stop, input int at, input logic [31:0] pair);
    while (cyc < stop) step((cyc + 1) == at, pair);
  endtask

  // Receiver: samples sdata on bclk rises, a word-select change marks the
  // delay bit, the next SW bits are the word, the remainder must be zero.
  int          slot = -1;
  int          rx_n = 0;
  logic        lr_prev = 1'b0, bclk_prev = 1'b0;
  logic [15:0] rl = '0, rr = '0;

  always @(negedge clk) begin
    if (rst) begin
      slot      = -1;
      lr_prev   = 1'b0;
      bclk_prev = 1'b0;
    end else begin
      if (bclk && !bclk_prev) begin
        if (lrclk != lr_prev) begin
          if (lr_prev && !lrclk) begin
            rx_n++;
            expect_eq("rx_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) expect_eq("rx_pair", {rl, rr}, exp_q.pop_front());
          end
          slot = 0;
        end else begin
          slot++;
        end
        lr_prev = lrclk;
        if (slot >= 1 && slot <= SW) begin
          if (lrclk) rr = {rr[14:0], sdata};
          else       rl = {rl[14:0], sdata};
        end else begin
          expect_eq("pad_bit", 32'(sdata), 0);
        end
      end
      bclk_prev = bclk;
    end
  end

  initial begin
    logic [31:0] p1, p2, px, pc, pr;
    p1 = $urandom;
    p2 = $urandom;
    px = $urandom;
    pc = {16'h1234, 16'($urandom)};
    pr = $urandom;

    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    run_to(200, 100, 32'hA5F0_8001);          // frame 0 accept
    run_to(2 * FRAME + 99, 0, '0);            // frame 1 idle -> underrun
    run_to(2 * FRAME + 100, 2 * FRAME + 100, p1);
    run_to(2 * FRAME + 200, 2 * FRAME + 200, p2);   // rejected
    run_to(3 * FRAME + 50, 3 * FRAME + 50, px);
    run_to(4 * FRAME, 4 * FRAME, pc);         // coincident with boundary load
    while (cyc < 9 * FRAME + FRAME / 2 + 500)
      step($urandom_range(0, 299) == 0, $urandom);

    // Mid-right-slot reset
    rst = 1'b1;
    #1;
    check_reset("midrst");
    cyc    = 0;
    m_full = 1'b0;
    m_hold = '0;
    m_cur  = '0;
    e_fs   = 1'b0;
    e_ur   = 1'b0;
    e_ov   = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_reset("inrst");
    rst = 1'b0;

    run_to(10, 10, pr);
    run_to(2 * FRAME + 100, 0, '0);

    expect_eq("exp_left", 32'(exp_q.size()), 0);
    expect_eq("rx_count", 32'(rx_n), 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
